// File: rtl/spi_adc128s_pkg.sv
// Shared constants for the ADC128S SPI slave front-end.
package spi_adc128s_pkg;

   localparam int unsigned WordW            = 16;
   localparam int unsigned DefaultFrameBits = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous serial input.
// Provides the synchronized level plus single-clk rise/fall strobes.
module spi_sync_edge #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [2:0] ff_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q <= {3{ResetVal}};
      end else begin
         ff_q <= {ff_q[1:0], d};
      end
   end

   // ff_q[1] is the synchronized level; ff_q[2] is its previous value
   assign sync = ff_q[1];
   assign rise = ff_q[1] & ~ff_q[2];
   assign fall = ~ff_q[1] & ff_q[2];

endmodule

// File: rtl/spi_adc128s.sv
// SPI mode-0 slave front-end for the ADC128S model: shifts A2D_data out on
// MISO, captures the 16-bit command on MOSI, and flags completed frames.
module spi_adc128s
   import spi_adc128s_pkg::*;
#(
   parameter int unsigned FRAME_BITS = DefaultFrameBits
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             SS_n,
   input  logic             SCLK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [WordW-1:0] A2D_data,
   output logic [WordW-1:0] cmd,
   output logic             rdy
);

   localparam int unsigned CntW = $clog2(FRAME_BITS + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);

   logic ss_sync, ss_rise, ss_fall;
   logic sclk_sync, sclk_rise, sclk_fall;
   logic [1:0] mosi_q;

   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WordW-1:0] rx_q, rx_d;
   logic [WordW-1:0] tx_q, tx_d;
   logic [WordW-1:0] cmd_q, cmd_d;
   logic             rdy_q, rdy_d;

   spi_sync_edge #(
      .ResetVal(1'b1)
   ) u_ss_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (SS_n),
      .sync (ss_sync),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   spi_sync_edge #(
      .ResetVal(1'b0)
   ) u_sclk_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (SCLK),
      .sync (sclk_sync),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_q <= 2'b00;
         cnt_q  <= '0;
         rx_q   <= '0;
         tx_q   <= '0;
         cmd_q  <= '0;
         rdy_q  <= 1'b0;
      end else begin
         mosi_q <= {mosi_q[0], MOSI};
         cnt_q  <= cnt_d;
         rx_q   <= rx_d;
         tx_q   <= tx_d;
         cmd_q  <= cmd_d;
         rdy_q  <= rdy_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      rx_d  = rx_q;
      tx_d  = tx_q;
      cmd_d = cmd_q;
      rdy_d = rdy_q;
      if (ss_sync) begin
         // Idle: keep the return word fresh so MISO is valid as soon as SS_n falls
         tx_d  = A2D_data;
         cnt_d = '0;
         if (ss_rise && (cnt_q == CntFull)) begin
            cmd_d = rx_q;
            rdy_d = 1'b1;
         end
      end else if (ss_fall) begin
         rdy_d = 1'b0;
         cnt_d = '0;
      end else begin
         if (sclk_rise) begin
            rx_d = {rx_q[WordW-2:0], mosi_q[1]};
            if (cnt_q != CntFull) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         if (sclk_fall) begin
            tx_d = {tx_q[WordW-2:0], 1'b0};
         end
      end
   end

   // Raw SS_n so the bus is released without synchronizer delay
   assign MISO = SS_n ? 1'bz : tx_q[WordW-1];
   assign cmd  = cmd_q;
   assign rdy  = rdy_q;

   logic unused_sclk_sync;
   assign unused_sclk_sync = sclk_sync;

endmodule

// File: tb/tb_spi_adc128s.sv
// Directed bench for spi_adc128s: a mode-0 master plus a frame-level model of
// cmd/rdy checked every cycle they are stable.
module tb_spi_adc128s;

   localparam int Half = 10;  // clk periods per SCLK half-period

   logic        clk = 1'b0;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   wire         MISO;
   logic [15:0] A2D_data;
   logic [15:0] cmd;
   logic        rdy;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level model state
   logic [15:0] exp_cmd = 16'h0000;
   logic        exp_rdy = 1'b0;
   bit          chk_en  = 1'b0;
   int          exp_rdy_edges = 0;
   int          rdy_edges = 0;
   logic        rdy_prev = 1'b0;

   always #5 clk = ~clk;

   spi_adc128s dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .A2D_data(A2D_data),
      .cmd     (cmd),
      .rdy     (rdy)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model while outputs are settled
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_model", cmd, exp_cmd);
         check("rdy_model", {15'b0, rdy}, {15'b0, exp_rdy});
      end
      if (rdy && !rdy_prev) rdy_edges++;
      rdy_prev = rdy;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One mode-0 frame of nbits SCLK pulses; optionally changes A2D_data mid-frame.
   task automatic frame(input logic [15:0] mo, input int nbits, input bit chg,
                        input logic [15:0] new_a2d, output logic [15:0] mi);
      logic prev_rdy;
      bit   valid;
      valid    = (nbits == 16);
      prev_rdy = exp_rdy;
      mi       = 16'h0000;
      chk_en   = 1'b0;
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = mo[15];
      exp_rdy = 1'b0;
      wait_clks(4);
      check("rdy_clear", {15'b0, rdy}, 16'h0000);
      chk_en = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         if (i < 16) mi[15-i] = MISO;
         SCLK = 1'b1;
         wait_clks(Half);
         SCLK = 1'b0;
         if (chg && i == 5) A2D_data = new_a2d;
         MOSI = (i + 1 < 16) ? mo[14-i] : 1'b0;
         wait_clks(Half);
      end
      chk_en = 1'b0;
      SS_n = 1'b1;
      wait_clks(2);
      check("rdy_latency_early", {15'b0, rdy}, 16'h0000);
      wait_clks(1);
      check("rdy_latency", {15'b0, rdy}, {15'b0, valid});
      if (valid) begin
         exp_cmd = mo;
         exp_rdy = 1'b1;
         exp_rdy_edges++;
      end
      chk_en = 1'b1;
      wait_clks(6);
      if (prev_rdy) begin end
   endtask

   logic [15:0] rd;

   initial begin
      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; A2D_data = 16'h0000;
      wait_clks(3);
      check("reset_cmd", cmd, 16'h0000);
      check("reset_rdy", {15'b0, rdy}, 16'h0000);
      rst_n = 1'b1;
      wait_clks(3);
      chk_en = 1'b1;

      // Basic frame
      A2D_data = 16'h0C00;
      frame(16'h2000, 16, 1'b0, 16'h0000, rd);
      check("basic_miso", rd, 16'h0C00);
      check("basic_cmd", cmd, 16'h2000);
      check("basic_rdy", {15'b0, rdy}, 16'h0001);

      // Back-to-back frames
      A2D_data = 16'h0C04;
      frame(16'h2000, 16, 1'b0, 16'h0000, rd);
      check("b2b1_miso", rd, 16'h0C04);
      check("b2b1_cmd", cmd, 16'h2000);
      A2D_data = 16'h0BF4;
      frame(16'h2800, 16, 1'b0, 16'h0000, rd);
      check("b2b2_miso", rd, 16'h0BF4);
      check("b2b2_cmd", cmd, 16'h2800);

      // Short frame is discarded
      A2D_data = 16'h0555;
      frame(16'h4000, 10, 1'b0, 16'h0000, rd);
      check("short_cmd", cmd, 16'h2800);
      check("short_rdy", {15'b0, rdy}, 16'h0000);

      // A2D_data change mid-frame must not corrupt the word in flight
      A2D_data = 16'h0BE5;
      frame(16'h0800, 16, 1'b1, 16'hFFFF, rd);
      check("midchg_miso", rd, 16'h0BE5);
      check("midchg_cmd", cmd, 16'h0800);
      check("miso_release", {15'b0, MISO === 1'b1}, 16'h0000);

      // SCLK toggling while deselected is ignored
      for (int i = 0; i < 20; i++) begin
         SCLK = ~SCLK;
         MOSI = 1'($urandom);
         wait_clks(Half);
      end
      SCLK = 1'b0;
      wait_clks(Half);
      A2D_data = 16'h0123;
      frame(16'h3000, 16, 1'b0, 16'h0000, rd);
      check("idle_miso", rd, 16'h0123);
      check("idle_cmd", cmd, 16'h3000);

      // Reset mid-frame
      chk_en = 1'b0;
      SS_n = 1'b0;
      MOSI = 1'b1;
      wait_clks(4);
      for (int i = 0; i < 8; i++) begin
         SCLK = 1'b1; wait_clks(Half);
         SCLK = 1'b0; wait_clks(Half);
      end
      rst_n = 1'b0;
      wait_clks(2);
      check("midrst_cmd", cmd, 16'h0000);
      check("midrst_rdy", {15'b0, rdy}, 16'h0000);
      rst_n = 1'b1;
      wait_clks(4);
      SS_n = 1'b1;
      exp_cmd = 16'h0000;
      exp_rdy = 1'b0;
      wait_clks(4);
      chk_en = 1'b1;
      A2D_data = 16'h0ABC;
      frame(16'h1234, 16, 1'b0, 16'h0000, rd);
      check("postrst_miso", rd, 16'h0ABC);
      check("postrst_cmd", cmd, 16'h1234);

      chk_en = 1'b0;
      check("rdy_edges", 16'(rdy_edges), 16'(exp_rdy_edges));
      check("rdy_edges_lit", 16'(rdy_edges), 16'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
